// File: rtl/axis_counter_checker_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// axis_counter_checker_if : AXI4-Stream tvalid/tready/tdata/tuser bundle
// Revision: 1.0
// ============================================================
interface axis_counter_checker_if #(
  parameter int BDATA = 16,
  parameter int BUSER = 8
);
  logic             tvalid;
  logic             tready;
  logic [BDATA-1:0] tdata;
  logic [BUSER-1:0] tuser;

  modport master (output tvalid, output tdata, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_counter_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// axis_counter_checker : throttled AXI4-Stream sink that checks an
// incrementing tdata / constant tuser stream and reports status.
// Revision: 1.0
// ============================================================
module axis_counter_checker #(
  parameter int BDATA = 16,
  parameter int BUSER = 8
) (
  input  wire               aclk,
  input  wire               areset,
  axis_counter_checker_if.slave s_axis,
  input  wire               START_REG,
  input  wire  [31:0]       NDATA_REG,
  input  wire  [31:0]       NUSER_REG,
  input  wire  [15:0]       READY_REG,
  input  wire  [31:0]       TIMEOUT_REG,
  output logic              BUSY_REG,
  output logic              DONE_REG,
  output logic              TIMEOUT_FLAG_REG,
  output logic [31:0]       RXCNT_REG,
  output logic [31:0]       ERRCNT_REG,
  output logic [31:0]       ERRIDX_REG,
  output logic [BDATA-1:0]  ERRDATA_REG,
  output logic [BUSER-1:0]  ERRUSER_REG
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]       r_state;
  logic             r_start_d;
  logic [31:0]      r_ndata;
  logic [BUSER-1:0] r_nuser;
  logic [15:0]      r_period;
  logic [31:0]      r_timeout;
  logic [15:0]      r_thr;
  logic             r_tready;
  logic [31:0]      r_idle;
  logic [BDATA-1:0] r_expect;
  logic [31:0]      r_rxcnt;
  logic [31:0]      r_errcnt;
  logic [31:0]      r_erridx;
  logic [BDATA-1:0] r_errdata;
  logic [BUSER-1:0] r_erruser;
  logic             r_err_seen;
  logic             r_to_flag;

  logic [1:0]  w_state_next;
  logic [15:0] w_thr_next;
  logic        w_start_rise;
  logic        w_beat;
  logic        w_mismatch;
  logic        w_last_beat;
  logic        w_timeout;

  generate
    if (BUSER < 32) begin : g_nuser_hi
      logic w_unused_nuser_hi;
      assign w_unused_nuser_hi = |NUSER_REG[31:BUSER];
    end
  endgenerate

  assign w_start_rise = START_REG && !r_start_d;
  assign w_beat       = (r_state == c_run) && s_axis.tvalid && r_tready;
  assign w_mismatch   = (s_axis.tdata != r_expect) || (s_axis.tuser != r_nuser);
  assign w_last_beat  = w_beat && ((r_rxcnt + 32'd1) == r_ndata);
  // A beat in the same cycle as the compare keeps the run alive.
  assign w_timeout    = (r_state == c_run) && !w_beat && (r_timeout != 32'd0) &&
                        ((r_idle + 32'd1) == r_timeout);

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= c_idle;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_start_d <= START_REG;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_start_rise) begin
      w_state_next = (NDATA_REG == 32'd0) ? c_done : c_run;
    end else if ((r_state == c_run) && (w_last_beat || w_timeout)) begin
      w_state_next = c_done;
    end
  end

  // Output decode
  always_comb begin
    BUSY_REG = 1'b0;
    DONE_REG = 1'b0;
    case (r_state)
      c_run:   BUSY_REG = 1'b1;
      c_done:  DONE_REG = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_thr_next = r_thr;
    if (w_start_rise) begin
      w_thr_next = 16'd0;
    end else if (r_state == c_run) begin
      w_thr_next = (r_thr == r_period) ? 16'd0 : r_thr + 16'd1;
    end
  end

  // tready is registered from the next state so it drops the cycle DONE is entered
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_thr    <= 16'd0;
      r_tready <= 1'b0;
    end else begin
      r_thr    <= w_thr_next;
      r_tready <= (w_state_next == c_run) && (w_thr_next == 16'd0);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ndata    <= 32'd0;
      r_nuser    <= '0;
      r_period   <= 16'd0;
      r_timeout  <= 32'd0;
      r_idle     <= 32'd0;
      r_expect   <= '0;
      r_rxcnt    <= 32'd0;
      r_errcnt   <= 32'd0;
      r_erridx   <= 32'd0;
      r_errdata  <= '0;
      r_erruser  <= '0;
      r_err_seen <= 1'b0;
      r_to_flag  <= 1'b0;
    end else if (w_start_rise) begin
      r_ndata    <= NDATA_REG;
      r_nuser    <= NUSER_REG[BUSER-1:0];
      r_period   <= READY_REG;
      r_timeout  <= TIMEOUT_REG;
      r_idle     <= 32'd0;
      r_expect   <= '0;
      r_rxcnt    <= 32'd0;
      r_errcnt   <= 32'd0;
      r_erridx   <= 32'd0;
      r_errdata  <= '0;
      r_erruser  <= '0;
      r_err_seen <= 1'b0;
      r_to_flag  <= 1'b0;
    end else if (r_state == c_run) begin
      if (w_beat) begin
        r_idle   <= 32'd0;
        r_expect <= r_expect + BDATA'(1);
        r_rxcnt  <= r_rxcnt + 32'd1;
        if (w_mismatch) begin
          if (r_errcnt != 32'hFFFF_FFFF) begin
            r_errcnt <= r_errcnt + 32'd1;
          end
          if (!r_err_seen) begin
            r_err_seen <= 1'b1;
            r_erridx   <= r_rxcnt;
            r_errdata  <= s_axis.tdata;
            r_erruser  <= s_axis.tuser;
          end
        end
      end else begin
        r_idle <= r_idle + 32'd1;
        if (w_timeout) begin
          r_to_flag <= 1'b1;
        end
      end
    end
  end

  assign s_axis.tready    = r_tready;
  assign TIMEOUT_FLAG_REG = r_to_flag;
  assign RXCNT_REG        = r_rxcnt;
  assign ERRCNT_REG       = r_errcnt;
  assign ERRIDX_REG       = r_erridx;
  assign ERRDATA_REG      = r_errdata;
  assign ERRUSER_REG      = r_erruser;

endmodule
`default_nettype wire

// File: tb/tb_axis_counter_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// tb_axis_counter_checker : directed stimulus with a run-status scoreboard
// Revision: 1.0
// ============================================================
module tb_axis_counter_checker;

  typedef struct packed {
    logic [31:0] rx;
    logic [31:0] err;
    logic [31:0] idx;
    logic [15:0] data;
    logic [7:0]  user;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        areset;
  logic        start_reg, start4;
  logic [31:0] ndata, nuser, timeout;
  logic [15:0] ready;

  logic        busy, done, toflag;
  logic [31:0] rxcnt, errcnt, erridx;
  logic [15:0] errdata;
  logic [7:0]  erruser;

  logic        busy4, done4, toflag4;
  logic [31:0] rxcnt4, errcnt4, erridx4;
  logic [3:0]  errdata4;
  logic [7:0]  erruser4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q_main[$];
  exp_t q_w4[$];
  logic done_prev  = 1'b0;
  logic done4_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_counter_checker_if #(.BDATA(16), .BUSER(8)) s_axis ();
  axis_counter_checker_if #(.BDATA(4),  .BUSER(8)) s_axis4 ();

  // The 4-bit instance sees the low nibble of the same stream
  assign s_axis4.tvalid = s_axis.tvalid;
  assign s_axis4.tdata  = s_axis.tdata[3:0];
  assign s_axis4.tuser  = s_axis.tuser;

  axis_counter_checker #(.BDATA(16), .BUSER(8)) u_dut (
    .aclk(clk), .areset(areset), .s_axis(s_axis),
    .START_REG(start_reg), .NDATA_REG(ndata), .NUSER_REG(nuser),
    .READY_REG(ready), .TIMEOUT_REG(timeout),
    .BUSY_REG(busy), .DONE_REG(done), .TIMEOUT_FLAG_REG(toflag),
    .RXCNT_REG(rxcnt), .ERRCNT_REG(errcnt), .ERRIDX_REG(erridx),
    .ERRDATA_REG(errdata), .ERRUSER_REG(erruser)
  );

  axis_counter_checker #(.BDATA(4), .BUSER(8)) u_dut4 (
    .aclk(clk), .areset(areset), .s_axis(s_axis4),
    .START_REG(start4), .NDATA_REG(ndata), .NUSER_REG(nuser),
    .READY_REG(ready), .TIMEOUT_REG(timeout),
    .BUSY_REG(busy4), .DONE_REG(done4), .TIMEOUT_FLAG_REG(toflag4),
    .RXCNT_REG(rxcnt4), .ERRCNT_REG(errcnt4), .ERRIDX_REG(erridx4),
    .ERRDATA_REG(errdata4), .ERRUSER_REG(erruser4)
  );

  function automatic exp_t mk(input logic [31:0] rx, input logic [31:0] err,
                              input logic [31:0] idx, input logic [15:0] data,
                              input logic [7:0] user, input logic to);
    exp_t e;
    e.rx = rx; e.err = err; e.idx = idx; e.data = data; e.user = user; e.to = to;
    return e;
  endfunction

  // Completed-run monitors: every DONE rising edge consumes one expected record
  always @(negedge clk) begin
    exp_t got, e;
    if (done && !done_prev) begin
      got = mk(rxcnt, errcnt, erridx, errdata, erruser, toflag);
      n_tests++;
      if (q_main.size() == 0) begin
        n_fail++;
        $display("FAIL run_status unexpected DONE at cycle %0d rx=%0d", cyc, rxcnt);
      end else begin
        e = q_main.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL run_status got rx=%0d err=%0d idx=%0d data=0x%0h user=0x%0h to=%0b exp rx=%0d err=%0d idx=%0d data=0x%0h user=0x%0h to=%0b",
                   got.rx, got.err, got.idx, got.data, got.user, got.to,
                   e.rx, e.err, e.idx, e.data, e.user, e.to);
        end
      end
    end
    done_prev = done;
  end

  always @(negedge clk) begin
    exp_t got, e;
    if (done4 && !done4_prev) begin
      got = mk(rxcnt4, errcnt4, erridx4, {12'h000, errdata4}, erruser4, toflag4);
      n_tests++;
      if (q_w4.size() == 0) begin
        n_fail++;
        $display("FAIL run_status4 unexpected DONE at cycle %0d rx=%0d", cyc, rxcnt4);
      end else begin
        e = q_w4.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL run_status4 got rx=%0d err=%0d idx=%0d data=0x%0h exp rx=%0d err=%0d idx=%0d data=0x%0h",
                   got.rx, got.err, got.idx, got.data, e.rx, e.err, e.idx, e.data);
        end
      end
    end
    done4_prev = done4;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge
  task automatic arm(input logic both);
    start_reg = 1'b1;
    start4    = both;
    @(negedge clk);
    start_reg = 1'b0;
    start4    = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the beat was taken
  task automatic send_beat(input logic [15:0] d, input logic [7:0] u);
    int w;
    w = 0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tuser  = u;
    while (!s_axis.tready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!s_axis.tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_wait tready stuck low for data=0x%0h", d);
    end else begin
      @(negedge clk);
    end
    s_axis.tvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, beats;
    logic bt;
    areset = 1'b1; start_reg = 1'b0; start4 = 1'b0;
    ndata = 32'd0; nuser = 32'h5A; ready = 16'd0; timeout = 32'd0;
    s_axis.tvalid = 1'b0; s_axis.tdata = 16'h0; s_axis.tuser = 8'h0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tready", s_axis.tready, 0);
    chk("reset_rxcnt", rxcnt, 0);
    chk("reset_errcnt", errcnt, 0);

    // Back-to-back stream, no throttle
    ndata = 32'd8; ready = 16'd0;
    q_main.push_back(mk(8, 0, 0, 16'h0, 8'h0, 1'b0));
    arm(1'b0);
    c0 = cyc;
    chk("t1_busy", busy, 1);
    chk("t1_tready_first", s_axis.tready, 1);
    for (int i = 0; i < 8; i++) send_beat(16'(i), 8'h5A);
    chk("t1_cycles", 32'(cyc - c0), 8);
    s_axis.tvalid = 1'b1; s_axis.tdata = 16'd8;
    for (int i = 0; i < 3; i++) begin
      chk("t1_tready_after_last", s_axis.tready, 0);
      @(negedge clk);
    end
    s_axis.tvalid = 1'b0;
    chk("t1_rxcnt", rxcnt, 8);
    chk("t1_done", done, 1);

    // Throttle P=3: tready in cycles 0,4,8,12 after RUN entry
    ndata = 32'd4; ready = 16'd3;
    q_main.push_back(mk(4, 0, 0, 16'h0, 8'h0, 1'b0));
    arm(1'b0);
    beats = 0;
    s_axis.tvalid = 1'b1; s_axis.tuser = 8'h5A; s_axis.tdata = 16'd0;
    for (int c = 0; c < 13; c++) begin
      chk($sformatf("t2_tready_c%0d", c), s_axis.tready, ((c % 4) == 0) ? 1 : 0);
      bt = s_axis.tready;
      @(negedge clk);
      if (bt) begin
        beats++;
        s_axis.tdata = 16'(beats);
      end
    end
    s_axis.tvalid = 1'b0;
    chk("t2_done_after_4th", done, 1);
    chk("t2_tready_in_done", s_axis.tready, 0);

    // Data error at beat 2, user error at beat 4
    ndata = 32'd6; ready = 16'd0;
    q_main.push_back(mk(6, 2, 2, 16'h0077, 8'h5A, 1'b0));
    arm(1'b0);
    for (int i = 0; i < 6; i++)
      send_beat((i == 2) ? 16'h0077 : 16'(i), (i == 4) ? 8'h00 : 8'h5A);
    chk("t3_errcnt", errcnt, 2);
    chk("t3_erridx", erridx, 2);

    // Counter wrap: 4-bit instance sees 0..15,0..3; 16-bit instance flags beats 16..19
    ndata = 32'd20;
    q_main.push_back(mk(20, 4, 16, 16'h0000, 8'h5A, 1'b0));
    q_w4.push_back(mk(20, 0, 0, 16'h0, 8'h0, 1'b0));
    arm(1'b1);
    for (int i = 0; i < 20; i++) send_beat(16'(i % 16), 8'h5A);
    chk("t4_errcnt4", errcnt4, 0);

    // Timeout of 10 idle cycles after the third beat
    ndata = 32'd8; timeout = 32'd10;
    q_main.push_back(mk(3, 0, 0, 16'h0, 8'h0, 1'b1));
    arm(1'b0);
    for (int i = 0; i < 3; i++) send_beat(16'(i), 8'h5A);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 9) begin
        chk("t5_busy_before_timeout", busy, 1);
        chk("t5_flag_before_timeout", toflag, 0);
      end
    end
    chk("t5_done", done, 1);
    chk("t5_flag", toflag, 1);
    chk("t5_rxcnt", rxcnt, 3);

    // Timeout disabled: stays busy
    timeout = 32'd0;
    arm(1'b0);
    for (int i = 0; i < 3; i++) send_beat(16'(i), 8'h5A);
    repeat (30) @(negedge clk);
    chk("t5b_busy", busy, 1);
    chk("t5b_done", done, 0);
    chk("t5b_rxcnt", rxcnt, 3);

    // Zero-length run goes straight to DONE
    ndata = 32'd0;
    q_main.push_back(mk(0, 0, 0, 16'h0, 8'h0, 1'b0));
    arm(1'b0);
    chk("t6_done", done, 1);
    chk("t6_rxcnt", rxcnt, 0);
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_tready", s_axis.tready, 0);
      @(negedge clk);
    end
    s_axis.tvalid = 1'b0;

    // Restart mid-run clears everything
    ndata = 32'd5;
    q_main.push_back(mk(5, 0, 0, 16'h0, 8'h0, 1'b0));
    arm(1'b0);
    send_beat(16'd0, 8'h5A);
    send_beat(16'd9, 8'h5A);
    send_beat(16'd2, 8'h5A);
    chk("t7_rxcnt_pre", rxcnt, 3);
    chk("t7_errcnt_pre", errcnt, 1);
    arm(1'b0);
    chk("t7_rxcnt_clr", rxcnt, 0);
    chk("t7_errcnt_clr", errcnt, 0);
    chk("t7_erridx_clr", erridx, 0);
    chk("t7_busy", busy, 1);
    for (int i = 0; i < 5; i++) send_beat(16'(i), 8'h5A);
    chk("t7_done", done, 1);

    // Reset mid-run
    ndata = 32'd8;
    arm(1'b0);
    send_beat(16'd5, 8'h5A);
    send_beat(16'd1, 8'h5A);
    chk("t8_errdata_pre", errdata, 32'h5);
    chk("t8_rxcnt_pre", rxcnt, 2);
    areset = 1'b1;
    @(negedge clk);
    chk("t8_busy", busy, 0);
    chk("t8_tready", s_axis.tready, 0);
    chk("t8_rxcnt", rxcnt, 0);
    chk("t8_errcnt", errcnt, 0);
    chk("t8_errdata", errdata, 0);
    chk("t8_erruser", erruser, 0);
    chk("t8_done4", done4, 0);
    areset = 1'b0;

    repeat (3) @(negedge clk);
    chk("q_main_empty", q_main.size(), 0);
    chk("q_w4_empty", q_w4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
